uart_rx: RTL and testbench

Asynchronous serial receiver that consumes the 8N1 line produced by `uart_tx`: fixed-rate mid-bit sampling, LSB-first, one start bit, eight data bits, one stop bit. It sits on the board's RX pin and hands each received byte to downstream logic (LED display, loopback to `uart_tx`) as a one-cycle strobe with the byte held stable. Framing errors are flagged, and the receiver resynchronises cleanly after a line break.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs, with selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle valid/framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       idx_d, idx_q;
  logic [7:0]       shreg_d, shreg_q;
  logic [7:0]       data_d, data_q;
  logic             dv_d, dv_q;
  logic             fe_d, fe_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit must still be low at its midpoint, otherwise it was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line recovers so a break yields only one error.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed and random frames.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  // Pin falling edge to output strobe: 3 edges to START, then H + 9 bit periods.
  localparam int LAT = 3 + H + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] b;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_byte = 8'h00;
  int         checks = 0;
  int         failures = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         last_dv_cyc = 0;
  int         prev_dv_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) cycle=%0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Every cycle: strobes and data_out must match the frame-level expectations.
  always @(negedge clk) begin
    bit  e_dv;
    bit  e_fe;
    ev_t ev;
    e_dv = 1'b0;
    e_fe = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      ev = exp_q.pop_front();
      if (ev.err) e_fe = 1'b1;
      else begin
        e_dv       = 1'b1;
        model_byte = ev.b;
      end
    end
    check("data_valid", int'(data_valid), int'(e_dv));
    check("frame_err", int'(frame_err), int'(e_fe));
    check("data_out", int'(data_out), int'(model_byte));
    if (data_valid) begin
      dv_cnt++;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int k);
    rx = v;
    tick(k);
  endtask

  task automatic expect_event(input int at, input bit err, input logic [7:0] b);
    ev_t ev;
    ev.at  = at;
    ev.err = err;
    ev.b   = b;
    exp_q.push_back(ev);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    expect_event(cyc + LAT, !stop_ok, b);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok, CPB);
  endtask

  initial begin
    int         busy_cnt;
    int         dv_before;
    logic [7:0] rb;
    logic [7:0] rnd_b;
    bit         rnd_ok;
    bit         prev_bad;
    int         gap;

    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("reset_data_out", int'(data_out), 0);
    check("reset_data_valid", int'(data_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Good frame and busy duration
    busy_cnt = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < 170; i++) begin
          @(negedge clk);
          if (busy) busy_cnt++;
        end
      end
    join
    tick(1);
    check("good_busy_cycles", busy_cnt, 152);
    check("good_data_out", int'(data_out), 8'h55);
    check("good_dv_count", dv_cnt, 1);

    // Back-to-back frames with no idle gap
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    tick(10);
    check("b2b_data_out", int'(data_out), 8'h00);
    check("b2b_dv_spacing", last_dv_cyc - prev_dv_cyc, 160);
    check("b2b_dv_count", dv_cnt, 3);

    // Start glitch of 4 cycles
    drive(1'b0, 4);
    rx = 1'b1;
    check("glitch_busy_high", int'(busy), 1);
    tick(7);
    check("glitch_busy_low", int'(busy), 0);
    tick(20);
    check("glitch_data_out", int'(data_out), 8'h00);
    check("glitch_no_pulse", dv_cnt + fe_cnt, 3);

    // Bad stop bit then recovery
    send_frame(8'hFF, 1'b0);
    rx = 1'b1;
    tick(10);
    check("badstop_fe_count", fe_cnt, 1);
    check("badstop_dv_count", dv_cnt, 3);
    check("badstop_data_out", int'(data_out), 8'h00);
    send_frame(8'h3C, 1'b1);
    tick(10);
    check("recover_data_out", int'(data_out), 8'h3C);

    // Line break for 40 bit times
    expect_event(cyc + LAT, 1'b1, 8'h00);
    drive(1'b0, 40 * CPB);
    check("break_busy_wait", int'(busy), 1);
    check("break_fe_count", fe_cnt, 2);
    rx = 1'b1;
    tick(10);
    check("break_busy_released", int'(busy), 0);
    send_frame(8'h81, 1'b1);
    tick(10);
    check("break_next_data_out", int'(data_out), 8'h81);

    // Reset asserted during bit 3 of 0xC6
    dv_before = dv_cnt;
    rb = 8'hC6;
    drive(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(rb[i], CPB);
    drive(rb[3], H);
    rst_n = 1'b0;
    exp_q.delete();
    model_byte = 8'h00;
    #1;
    check("midreset_data_out", int'(data_out), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_data_valid", int'(data_valid), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'h5A, 1'b1);
    tick(10);
    check("postreset_data_out", int'(data_out), 8'h5A);
    check("postreset_dv_count", dv_cnt, dv_before + 1);

    // Random frames, occasional bad stop bits, random idle gaps
    prev_bad = 1'b0;
    for (int f = 0; f < 40; f++) begin
      rnd_b  = 8'($urandom);
      rnd_ok = ($urandom_range(0, 4) != 0);
      gap    = int'($urandom_range(prev_bad ? 1 : 0, 6));
      rx = 1'b1;
      tick(gap);
      send_frame(rnd_b, rnd_ok);
      prev_bad = !rnd_ok;
    end
    rx = 1'b1;
    tick(LAT);
    check("pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
